// File: rtl/game_monitor.sv
// Tick-rate monitor for the game controller: infers WAIT/PLAY/OVER from pipe motion and
// drives BCD score, blink, coin and bird status. Define HIGH_SCORE_EN to keep a high score.
module game_monitor #(
   parameter int OVER_TICKS = 2,
   parameter int BLINK_DIV  = 5,
   parameter int SCORE_MAX  = 9999
) (
   input  logic        clk_100ms,
   input  logic        rst,
   input  logic [15:0] score,
   input  logic [15:0] bird_y,
   input  logic [31:0] pipe1,
   input  logic [31:0] pipe2,
   input  logic [31:0] pipe3,
   input  logic [31:0] coin,
   output logic [1:0]  state,
   output logic        game_over,
   output logic [15:0] bcd_score,
   output logic [15:0] bcd_high,
   output logic        new_record,
   output logic        blink,
   output logic        coin_taken,
   output logic        bird_rising
);

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   localparam logic [3:0]  OVER_CNT   = 4'(OVER_TICKS);
   localparam logic [7:0]  BLINK_LAST = 8'(BLINK_DIV - 1);
   localparam logic [13:0] SHADOW_MAX = 14'(SCORE_MAX);

   state_t      st;
   logic [9:0]  prev_x1, prev_x2, prev_x3;
   logic        prev_coin;
   logic        primed;
   logic [3:0]  freeze_cnt;
   logic [3:0]  freeze_nxt;
   logic [7:0]  blink_div;
   logic [13:0] shadow;
   logic [15:0] shadow_ext;
   logic        moved;
   logic        coin_fell;
   logic        unused_inputs;

   assign state = st;

   // The first tick after reset only loads the previous-sample registers, so the
   // reset value of prev_x* is never mistaken for pipe motion.
   assign moved = primed && ((pipe1[19:10] != prev_x1) ||
                             (pipe2[19:10] != prev_x2) ||
                             (pipe3[19:10] != prev_x3));
   assign coin_fell  = prev_coin && !coin[31];
   assign freeze_nxt = (freeze_cnt == 4'hF) ? freeze_cnt : freeze_cnt + 4'd1;
   assign shadow_ext = {2'b00, shadow};

   assign unused_inputs = ^{bird_y[14:0], pipe1[31:20], pipe1[9:0], pipe2[31:20], pipe2[9:0],
                            pipe3[31:20], pipe3[9:0], coin[30:0]};

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int d = 0; d < 4; d++) begin
         if (carry) begin
            if (v[d*4 +: 4] == 4'd9) begin
               r[d*4 +: 4] = 4'd0;
            end else begin
               r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk_100ms or negedge rst) begin
      if (!rst) begin
         st          <= ST_WAIT;
         prev_x1     <= '0;
         prev_x2     <= '0;
         prev_x3     <= '0;
         prev_coin   <= 1'b0;
         primed      <= 1'b0;
         freeze_cnt  <= '0;
         blink_div   <= '0;
         shadow      <= '0;
         bcd_score   <= '0;
         game_over   <= 1'b0;
         blink       <= 1'b0;
         coin_taken  <= 1'b0;
         bird_rising <= 1'b0;
      end else begin
         prev_x1     <= pipe1[19:10];
         prev_x2     <= pipe2[19:10];
         prev_x3     <= pipe3[19:10];
         prev_coin   <= coin[31];
         primed      <= 1'b1;
         bird_rising <= bird_y[15];
         coin_taken  <= 1'b0;

         case (st)
            ST_WAIT: begin
               if (moved) begin
                  st         <= ST_PLAY;
                  freeze_cnt <= '0;
               end
            end
            ST_PLAY: begin
               coin_taken <= coin_fell;
               if (moved) begin
                  freeze_cnt <= '0;
               end else begin
                  freeze_cnt <= freeze_nxt;
                  if (freeze_nxt >= OVER_CNT) begin
                     st        <= ST_OVER;
                     game_over <= 1'b1;
                     blink_div <= '0;
                     blink     <= 1'b0;
                  end
               end
            end
            ST_OVER: begin
               if (blink_div == BLINK_LAST) begin
                  blink_div <= '0;
                  blink     <= ~blink;
               end else begin
                  blink_div <= blink_div + 8'd1;
               end
            end
            default: st <= ST_WAIT;
         endcase

         // Follower climbs one count per tick; a score below it means the controller restarted.
         if ((shadow_ext < score) && (shadow < SHADOW_MAX)) begin
            shadow    <= shadow + 14'd1;
            bcd_score <= bcd_inc(bcd_score);
         end else if (score < shadow_ext) begin
            shadow    <= '0;
            bcd_score <= '0;
         end
      end
   end

`ifdef HIGH_SCORE_EN
   // High score deliberately has no reset so it survives between games.
   logic [13:0] high_shadow = '0;
   logic [15:0] high_bcd    = '0;
   logic        beat;

   assign beat     = (st == ST_OVER) && (shadow > high_shadow);
   assign bcd_high = high_bcd;

   always_ff @(posedge clk_100ms) begin
      if (beat) begin
         high_shadow <= shadow;
         high_bcd    <= bcd_score;
      end
   end

   always_ff @(posedge clk_100ms or negedge rst) begin
      if (!rst) begin
         new_record <= 1'b0;
      end else if (beat) begin
         new_record <= 1'b1;
      end
   end
`else
   assign bcd_high   = '0;
   assign new_record = 1'b0;
`endif

endmodule

// File: tb/tb_game_monitor.sv
// Bench for game_monitor: vector table plus hand sequences for reset, saturation and high score.
`timescale 1ns/1ps
module tb_game_monitor;

   logic        clk_100ms = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] score = '0;
   logic [15:0] bird_y = '0;
   logic [31:0] pipe1 = '0, pipe2 = '0, pipe3 = '0, coin = '0;
   logic [1:0]  state;
   logic        game_over, new_record, blink, coin_taken, bird_rising;
   logic [15:0] bcd_score, bcd_high;

   int n_cmp = 0;
   int n_err = 0;

   logic [21:0] exp_q[$];
   string       name_q[$];
   logic [21:0] mon_exp;
   string       mon_name;

   typedef struct {
      logic [9:0]  x1;
      logic        cb;
      logic        bb;
      logic [15:0] sc;
      logic [1:0]  st;
      logic        go;
      logic [15:0] bcd;
      logic        bl;
      logic        ct;
      logic        br;
   } vec_t;

   vec_t tbl[26];

   game_monitor dut (
      .clk_100ms  (clk_100ms),
      .rst        (rst),
      .score      (score),
      .bird_y     (bird_y),
      .pipe1      (pipe1),
      .pipe2      (pipe2),
      .pipe3      (pipe3),
      .coin       (coin),
      .state      (state),
      .game_over  (game_over),
      .bcd_score  (bcd_score),
      .bcd_high   (bcd_high),
      .new_record (new_record),
      .blink      (blink),
      .coin_taken (coin_taken),
      .bird_rising(bird_rising)
   );

   // clock / watchdog
   always #5 clk_100ms = ~clk_100ms;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, expected end of test");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "timeout");
   end

   function automatic void check(input string nm, input logic [21:0] act, input logic [21:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic logic [15:0] bin2bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [21:0] pack_exp(input logic [1:0] s, input logic go, input logic [15:0] b,
                                            input logic bl, input logic ct, input logic br);
      return {s, go, b, bl, ct, br};
   endfunction

   // driver tasks
   task automatic apply_in(input logic [9:0] x1, input logic cb, input logic bb, input logic [15:0] sc);
      pipe1  = {4'd0, 8'd60, x1, 10'd120};
      pipe2  = {4'd0, 8'd60, 10'd400, 10'd50};
      pipe3  = {4'd0, 8'd60, 10'd600, 10'd80};
      coin   = {cb, 11'd0, 10'd200, 10'd300};
      bird_y = {bb, 15'd240};
      score  = sc;
   endtask

   task automatic drive(input logic [9:0] x1, input logic cb, input logic bb, input logic [15:0] sc,
                        input logic [21:0] e, input string nm);
      @(negedge clk_100ms);
      apply_in(x1, cb, bb, sc);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // scoreboard: each edge retires the expectation pushed before it
   always @(posedge clk_100ms) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         check(mon_name, {state, game_over, bcd_score, blink, coin_taken, bird_rising}, mon_exp);
      end
   end

`ifdef HIGH_SCORE_EN
   task automatic play_game(input int s, input logic [15:0] hi_before);
      @(negedge clk_100ms);
      apply_in(10'd90, 1'b0, 1'b0, 16'(s));
      rst = 1'b0;
      #1;
      check("hs_new_record_rst", {21'd0, new_record}, 22'd0);
      check("hs_high_survives_rst", {6'd0, bcd_high}, {6'd0, hi_before});
      #1;
      rst = 1'b1;
      for (int i = 1; i <= s + 5; i++) begin
         @(negedge clk_100ms);
         apply_in(10'(90 - i), 1'b0, 1'b0, 16'(s));
      end
      repeat (4) @(negedge clk_100ms);
      @(negedge clk_100ms);
      check("hs_game_over", {20'd0, state}, {20'd0, 2'd2});
   endtask
`endif

   initial begin
      tbl[0]  = '{10'd210, 1'b0, 1'b0, 16'd0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{10'd208, 1'b0, 1'b0, 16'd0, 2'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{10'd206, 1'b0, 1'b1, 16'd0, 2'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{10'd204, 1'b0, 1'b0, 16'd3, 2'd1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{10'd202, 1'b0, 1'b0, 16'd3, 2'd1, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{10'd200, 1'b0, 1'b0, 16'd3, 2'd1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{10'd198, 1'b0, 1'b0, 16'd3, 2'd1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{10'd196, 1'b0, 1'b0, 16'd0, 2'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{10'd194, 1'b1, 1'b0, 16'd0, 2'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{10'd192, 1'b1, 1'b0, 16'd0, 2'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{10'd190, 1'b0, 1'b0, 16'd0, 2'd1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{10'd188, 1'b0, 1'b0, 16'd0, 2'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{10'd0,   1'b0, 1'b0, 16'd0, 2'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{10'd640, 1'b1, 1'b0, 16'd0, 2'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{10'd640, 1'b0, 1'b0, 16'd0, 2'd1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[15] = '{10'd640, 1'b0, 1'b0, 16'd0, 2'd2, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{10'd640, 1'b1, 1'b0, 16'd0, 2'd2, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[17] = '{10'd640, 1'b0, 1'b0, 16'd0, 2'd2, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[18] = '{10'd630, 1'b0, 1'b0, 16'd0, 2'd2, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[19] = '{10'd630, 1'b0, 1'b0, 16'd0, 2'd2, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[20] = '{10'd630, 1'b0, 1'b0, 16'd0, 2'd2, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
      tbl[21] = '{10'd630, 1'b0, 1'b0, 16'd2, 2'd2, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
      tbl[22] = '{10'd630, 1'b0, 1'b0, 16'd2, 2'd2, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
      tbl[23] = '{10'd630, 1'b0, 1'b0, 16'd2, 2'd2, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
      tbl[24] = '{10'd630, 1'b0, 1'b0, 16'd2, 2'd2, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
      tbl[25] = '{10'd630, 1'b0, 1'b0, 16'd2, 2'd2, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0};

      // reset state
      apply_in(10'd210, 1'b0, 1'b0, 16'd0);
      #12;
      check("reset_outputs", {state, game_over, bcd_score, blink, coin_taken, bird_rising}, 22'd0);
      check("reset_high", {5'd0, bcd_high, new_record}, 22'd0);
      @(negedge clk_100ms);
      rst = 1'b1;
      #1;
      exp_q.delete();
      name_q.delete();

      // table: the first vector is the priming tick, so its edge is the one right after release
      apply_in(tbl[0].x1, tbl[0].cb, tbl[0].bb, tbl[0].sc);
      exp_q.push_back(pack_exp(tbl[0].st, tbl[0].go, tbl[0].bcd, tbl[0].bl, tbl[0].ct, tbl[0].br));
      name_q.push_back("vec_0");
      for (int i = 1; i < 26; i++) begin
         drive(tbl[i].x1, tbl[i].cb, tbl[i].bb, tbl[i].sc,
               pack_exp(tbl[i].st, tbl[i].go, tbl[i].bcd, tbl[i].bl, tbl[i].ct, tbl[i].br),
               $sformatf("vec_%0d", i));
      end
      @(posedge clk_100ms);
      #2;

`ifndef HIGH_SCORE_EN
      check("no_high_score", {5'd0, bcd_high, new_record}, 22'd0);
`endif

      // asynchronous reset mid-game, away from any clock edge
      apply_in(10'd300, 1'b0, 1'b0, 16'd0);
      rst = 1'b0;
      #1;
      check("async_rst_mid_game", {state, game_over, bcd_score, blink, coin_taken, bird_rising}, 22'd0);
      @(negedge clk_100ms);
      rst = 1'b1;

      // saturation: score far above SCORE_MAX, follower must stop at 9999
      for (int k = 0; k < 10005; k++) begin
         drive(10'd300, 1'b0, 1'b0, 16'd12000,
               pack_exp(2'd0, 1'b0, bin2bcd((k + 1 < 9999) ? k + 1 : 9999), 1'b0, 1'b0, 1'b0),
               $sformatf("sat_tick_%0d", k));
      end
      drive(10'd300, 1'b0, 1'b0, 16'd0, pack_exp(2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0), "restart_to_zero");
      drive(10'd300, 1'b0, 1'b0, 16'd5, pack_exp(2'd0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0), "climb_after_zero");
      @(posedge clk_100ms);
      #2;

`ifdef HIGH_SCORE_EN
      play_game(7, bcd_high);
      check("hs_game1_high", {6'd0, bcd_high}, {6'd0, 16'h0007});
      check("hs_game1_record", {21'd0, new_record}, 22'd1);
      play_game(5, 16'h0007);
      check("hs_game2_high", {6'd0, bcd_high}, {6'd0, 16'h0007});
      check("hs_game2_record", {21'd0, new_record}, 22'd0);
      play_game(12, 16'h0007);
      check("hs_game3_high", {6'd0, bcd_high}, {6'd0, 16'h0012});
      check("hs_game3_record", {21'd0, new_record}, 22'd1);
`endif

      // final report
      @(posedge clk_100ms);
      #3;
      check("scoreboard_drained", 22'(exp_q.size()), 22'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
